// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
package data_mem_responder_pkg;

  localparam int WORD_W        = 32;
  localparam int MEM_WORDS_DEF = 64;
  localparam int IDX_W         = 6;

  // One store-log record: which word was written and with what.
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] data;
  } log_entry_t;

  // Word aligned and inside the 256-byte window.
  function automatic logic addr_aligned_in_window(logic [WORD_W-1:0] a);
    return (a[1:0] == 2'b00) && (a[31:8] == 24'h0);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Processor-side data bus plus store-log / status outputs.
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic [WORD_W-1:0] i_data_mem_addr;
  logic              i_data_mem_r_en;
  logic              i_data_mem_w_en;
  logic [WORD_W-1:0] i_data_mem_w_data;
  logic [WORD_W-1:0] o_data_mem_r_data;
  logic              o_fault;
  logic [WORD_W-1:0] o_fault_addr;
  logic              o_log_valid;
  logic              i_log_ready;
  logic [IDX_W-1:0]  o_log_idx;
  logic [WORD_W-1:0] o_log_data;
  logic              o_log_overflow;
  logic [15:0]       o_store_count;

  modport master (
    output i_data_mem_addr, i_data_mem_r_en, i_data_mem_w_en, i_data_mem_w_data, i_log_ready,
    input  o_data_mem_r_data, o_fault, o_fault_addr, o_log_valid, o_log_idx, o_log_data,
           o_log_overflow, o_store_count
  );

  modport slave (
    input  i_data_mem_addr, i_data_mem_r_en, i_data_mem_w_en, i_data_mem_w_data, i_log_ready,
    output o_data_mem_r_data, o_fault, o_fault_addr, o_log_valid, o_log_idx, o_log_data,
           o_log_overflow, o_store_count
  );
endinterface

// File: rtl/data_mem_responder_sync_fifo.sv
// Show-ahead synchronous FIFO. A push while full is only taken when a pop
// happens on the same edge; otherwise it is dropped (caller sees full).
module sync_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] store_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [AW:0]                 count_q;
  logic                        push, pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = pop_ready && !empty;
  assign push     = push_valid && (!full || pop);
  assign pop_data = store_q[rd_ptr_q];

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (!rst && push) store_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with combinational read, access-fault capture,
// a committed-store counter and a store log drained by a consumer.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int LOG_DEPTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  data_mem_responder_if.slave  bus
);
  logic [MEM_WORDS-1:0][WORD_W-1:0] mem_q;
  logic [WORD_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic              legal, commit, bad_access;
  logic              fault_q, overflow_q;
  logic [WORD_W-1:0] fault_addr_q;
  logic [15:0]       store_cnt_q;
  logic              log_full, log_empty, log_pop;
  log_entry_t        push_entry, head_entry;

  assign addr       = bus.i_data_mem_addr;
  assign idx        = addr[7:2];
  // One legality check serves both the read and the write port.
  assign legal      = addr_aligned_in_window(addr) && (int'(idx) < MEM_WORDS);
  assign commit     = bus.i_data_mem_w_en && legal;
  assign bad_access = (bus.i_data_mem_r_en || bus.i_data_mem_w_en) && !legal;
  assign log_pop    = !log_empty && bus.i_log_ready;

  // Combinational read of the pre-edge contents (read-before-write).
  always_comb begin
    bus.o_data_mem_r_data = '0;
    if (bus.i_data_mem_r_en && legal) bus.o_data_mem_r_data = mem_q[idx];
  end

  // Memory array; reset wins over a same-cycle write.
  always_ff @(posedge i_clk) begin
    if (i_rst)       mem_q      <= '0;
    else if (commit) mem_q[idx] <= bus.i_data_mem_w_data;
  end

  // Sticky fault; address latched only for the first offending access.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else if (bad_access) begin
      fault_q <= 1'b1;
      if (!fault_q) fault_addr_q <= addr;
    end
  end

  // Saturating committed-store counter and sticky log-overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      store_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (commit && store_cnt_q != 16'hFFFF) store_cnt_q <= store_cnt_q + 16'd1;
      if (commit && log_full && !log_pop)    overflow_q  <= 1'b1;
    end
  end

  assign push_entry = '{idx: idx, data: bus.i_data_mem_w_data};

  sync_fifo #(
    .WIDTH ($bits(log_entry_t)),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk        (i_clk),
    .rst        (i_rst),
    .push_valid (commit),
    .push_data  (push_entry),
    .pop_ready  (bus.i_log_ready),
    .pop_data   (head_entry),
    .full       (log_full),
    .empty      (log_empty)
  );

  assign bus.o_fault        = fault_q;
  assign bus.o_fault_addr   = fault_addr_q;
  assign bus.o_log_valid    = !log_empty;
  assign bus.o_log_idx      = head_entry.idx;
  assign bus.o_log_data     = head_entry.data;
  assign bus.o_log_overflow = overflow_q;
  assign bus.o_store_count  = store_cnt_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: read/write, faults, store log, reset.
module tb_data_mem_responder;
  logic i_clk = 1'b0;
  logic i_rst;
  data_mem_responder_if bus();

  data_mem_responder #(.MEM_WORDS(64), .LOG_DEPTH(8)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  logic [5:0]  eq_idx[$];
  logic [31:0] eq_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.i_data_mem_addr   = a;
    bus.i_data_mem_w_data = d;
    bus.i_data_mem_w_en   = 1'b1;
    bus.i_data_mem_r_en   = 1'b0;
    tick();
    bus.i_data_mem_w_en   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.i_data_mem_addr = a;
    bus.i_data_mem_r_en = 1'b1;
    #1;
    chk(tag, bus.o_data_mem_r_data, exp);
    bus.i_data_mem_r_en = 1'b0;
  endtask

  // Pop n entries and compare each against the expected-order queue.
  task automatic drain(input int n);
    logic [5:0]  ei;
    logic [31:0] ed;
    bus.i_log_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      ei = eq_idx.pop_front();
      ed = eq_data.pop_front();
      chk("drain_valid", {31'b0, bus.o_log_valid}, 32'd1);
      chk("drain_idx",   {26'b0, bus.o_log_idx}, {26'b0, ei});
      chk("drain_data",  bus.o_log_data, ed);
      tick();
    end
    bus.i_log_ready = 1'b0;
    chk("drain_empty", {31'b0, bus.o_log_valid}, 32'd0);
  endtask

  initial begin
    i_rst                 = 1'b1;
    bus.i_data_mem_addr   = '0;
    bus.i_data_mem_r_en   = 1'b0;
    bus.i_data_mem_w_en   = 1'b0;
    bus.i_data_mem_w_data = '0;
    bus.i_log_ready       = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;

    // reset state
    chk("rst_fault",    {31'b0, bus.o_fault}, 32'd0);
    chk("rst_faddr",    bus.o_fault_addr, 32'd0);
    chk("rst_lvalid",   {31'b0, bus.o_log_valid}, 32'd0);
    chk("rst_overflow", {31'b0, bus.o_log_overflow}, 32'd0);
    chk("rst_count",    {16'b0, bus.o_store_count}, 32'd0);
    rd_chk("rst_read0", 32'h0, 32'h0);

    // basic write then read next cycle
    wr(32'h0, 32'hfeedbeef);
    rd_chk("wr_read0", 32'h0, 32'hfeedbeef);
    chk("wr_count",  {16'b0, bus.o_store_count}, 32'd1);
    chk("wr_lvalid", {31'b0, bus.o_log_valid}, 32'd1);
    chk("wr_lidx",   {26'b0, bus.o_log_idx}, 32'd0);
    chk("wr_ldata",  bus.o_log_data, 32'hfeedbeef);
    eq_idx.push_back(6'd0); eq_data.push_back(32'hfeedbeef);
    drain(1);

    // same-cycle read and write: old data now, new data next cycle
    wr(32'h10, 32'h22);
    bus.i_data_mem_addr   = 32'h10;
    bus.i_data_mem_w_data = 32'h11;
    bus.i_data_mem_w_en   = 1'b1;
    bus.i_data_mem_r_en   = 1'b1;
    #1;
    chk("rw_old", bus.o_data_mem_r_data, 32'h22);
    tick();
    bus.i_data_mem_w_en = 1'b0;
    #1;
    chk("rw_new", bus.o_data_mem_r_data, 32'h11);
    bus.i_data_mem_r_en = 1'b0;
    chk("rw_count", {16'b0, bus.o_store_count}, 32'd3);
    eq_idx.push_back(6'd4); eq_data.push_back(32'h22);
    eq_idx.push_back(6'd4); eq_data.push_back(32'h11);
    drain(2);

    // misaligned write, then out-of-window read
    wr(32'h6, 32'h55);
    chk("flt_fault",  {31'b0, bus.o_fault}, 32'd1);
    chk("flt_faddr",  bus.o_fault_addr, 32'h6);
    chk("flt_count",  {16'b0, bus.o_store_count}, 32'd3);
    chk("flt_nolog",  {31'b0, bus.o_log_valid}, 32'd0);
    rd_chk("flt_rd104", 32'h104, 32'h0);
    bus.i_data_mem_r_en = 1'b1;
    tick();
    bus.i_data_mem_r_en = 1'b0;
    chk("flt_faddr_held", bus.o_fault_addr, 32'h6);
    rd_chk("flt_word1",  32'h4, 32'h0);
    rd_chk("flt_word0",  32'h0, 32'hfeedbeef);
    rd_chk("flt_word4",  32'h10, 32'h11);
    bus.i_data_mem_addr = 32'h0;
    #1;
    chk("no_ren_zero", bus.o_data_mem_r_data, 32'h0);

    // nine stores with the consumer stalled: eighth fills, ninth drops
    for (int k = 0; k < 9; k++) wr(32'(4 * k), 32'h100 + 32'(k));
    chk("ovf_flag",  {31'b0, bus.o_log_overflow}, 32'd1);
    chk("ovf_count", {16'b0, bus.o_store_count}, 32'd12);
    rd_chk("ovf_mem8", 32'h20, 32'h108);
    rd_chk("ovf_mem0", 32'h0, 32'h100);
    for (int k = 0; k < 8; k++) begin
      eq_idx.push_back(6'(k)); eq_data.push_back(32'h100 + 32'(k));
    end
    drain(8);

    // reset clears overflow and counters
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("rst2_overflow", {31'b0, bus.o_log_overflow}, 32'd0);
    chk("rst2_fault",    {31'b0, bus.o_fault}, 32'd0);
    chk("rst2_faddr",    bus.o_fault_addr, 32'd0);
    chk("rst2_count",    {16'b0, bus.o_store_count}, 32'd0);
    rd_chk("rst2_mem8",  32'h20, 32'h0);

    // full log with simultaneous pop and push
    for (int k = 0; k < 8; k++) wr(32'(4 * k), 32'h200 + 32'(k));
    chk("full_noovf", {31'b0, bus.o_log_overflow}, 32'd0);
    chk("full_head",  {26'b0, bus.o_log_idx}, 32'd0);
    bus.i_data_mem_addr   = 32'h24;
    bus.i_data_mem_w_data = 32'h2ff;
    bus.i_data_mem_w_en   = 1'b1;
    bus.i_log_ready       = 1'b1;
    tick();
    bus.i_data_mem_w_en = 1'b0;
    bus.i_log_ready     = 1'b0;
    chk("pp_noovf", {31'b0, bus.o_log_overflow}, 32'd0);
    chk("pp_head",  {26'b0, bus.o_log_idx}, 32'd1);
    chk("pp_count", {16'b0, bus.o_store_count}, 32'd9);
    for (int k = 1; k < 8; k++) begin
      eq_idx.push_back(6'(k)); eq_data.push_back(32'h200 + 32'(k));
    end
    eq_idx.push_back(6'd9); eq_data.push_back(32'h2ff);
    drain(8);

    // reset beats a same-cycle write and clears a pending fault
    bus.i_data_mem_addr = 32'h3;
    bus.i_data_mem_r_en = 1'b1;
    tick();
    bus.i_data_mem_r_en = 1'b0;
    chk("pre_fault", {31'b0, bus.o_fault}, 32'd1);
    i_rst                 = 1'b1;
    bus.i_data_mem_addr   = 32'h4;
    bus.i_data_mem_w_data = 32'hdead;
    bus.i_data_mem_w_en   = 1'b1;
    tick();
    i_rst               = 1'b0;
    bus.i_data_mem_w_en = 1'b0;
    chk("rstw_count",  {16'b0, bus.o_store_count}, 32'd0);
    chk("rstw_lvalid", {31'b0, bus.o_log_valid}, 32'd0);
    chk("rstw_fault",  {31'b0, bus.o_fault}, 32'd0);
    rd_chk("rstw_mem1", 32'h4, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
